// File: rtl/lfsr_bit_stats.sv
// Per-period statistics for a serial pseudo-random bit stream: ones, zeroes, runs, longest run
// and balance, handed out through a valid/ready result slice with a sticky overrun flag.
module lfsr_bit_stats #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned RUN_W   = 8,
  parameter int unsigned BAL_TOL = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in_i,
  input  logic             bit_valid_i,
  input  logic             period_tick_i,
  output logic [CNT_W-1:0] res_ones_o,
  output logic [CNT_W-1:0] res_zeroes_o,
  output logic [CNT_W-1:0] res_runs_o,
  output logic [RUN_W-1:0] res_longest_run_o,
  output logic             res_balanced_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_overrun_o
);

  localparam logic [CNT_W:0] BalTol = (CNT_W + 1)'(BAL_TOL);

  typedef enum logic {StIdle, StAccum} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] ones_q, zeroes_q, runs_q;
  logic [RUN_W-1:0] cur_run_q, longest_q;
  logic             last_bit_q;

  logic [CNT_W-1:0] res_ones_q, res_zeroes_q, res_runs_q;
  logic [RUN_W-1:0] res_longest_q;
  logic             res_balanced_q, res_valid_q, res_overrun_q;

  logic             tick;
  logic [RUN_W-1:0] longest_fin;
  logic [CNT_W:0]   diff;
  logic             balanced;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RUN_W-1:0] sat_run(input logic [RUN_W-1:0] v);
    return (&v) ? v : v + RUN_W'(1);
  endfunction

  always_comb begin
    tick        = period_tick_i & bit_valid_i;
    longest_fin = (cur_run_q > longest_q) ? cur_run_q : longest_q;
    if (ones_q >= zeroes_q) diff = {1'b0, ones_q} - {1'b0, zeroes_q};
    else                    diff = {1'b0, zeroes_q} - {1'b0, ones_q};
    balanced    = (diff <= BalTol);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      ones_q         <= '0;
      zeroes_q       <= '0;
      runs_q         <= '0;
      cur_run_q      <= '0;
      longest_q      <= '0;
      last_bit_q     <= 1'b0;
      res_ones_q     <= '0;
      res_zeroes_q   <= '0;
      res_runs_q     <= '0;
      res_longest_q  <= '0;
      res_balanced_q <= 1'b0;
      res_valid_q    <= 1'b0;
      res_overrun_q  <= 1'b0;
    end else begin
      if (res_valid_q && res_ready_i) res_valid_q <= 1'b0;
      if (tick) begin
        // Snapshot uses accumulators as they stand, i.e. excluding the tick bit.
        if (state_q == StAccum) begin
          res_ones_q     <= ones_q;
          res_zeroes_q   <= zeroes_q;
          res_runs_q     <= runs_q;
          res_longest_q  <= longest_fin;
          res_balanced_q <= balanced;
          res_valid_q    <= 1'b1;
          if (res_valid_q && !res_ready_i) res_overrun_q <= 1'b1;
        end
        state_q    <= StAccum;
        ones_q     <= {{(CNT_W-1){1'b0}}, bit_in_i};
        zeroes_q   <= {{(CNT_W-1){1'b0}}, ~bit_in_i};
        runs_q     <= CNT_W'(1);
        cur_run_q  <= RUN_W'(1);
        longest_q  <= '0;
        last_bit_q <= bit_in_i;
      end else if (bit_valid_i && state_q == StAccum) begin
        if (bit_in_i) ones_q   <= sat_cnt(ones_q);
        else          zeroes_q <= sat_cnt(zeroes_q);
        if (bit_in_i == last_bit_q) begin
          cur_run_q <= sat_run(cur_run_q);
        end else begin
          longest_q <= longest_fin;
          cur_run_q <= RUN_W'(1);
          runs_q    <= sat_cnt(runs_q);
        end
        last_bit_q <= bit_in_i;
      end
    end
  end

  assign res_ones_o        = res_ones_q;
  assign res_zeroes_o      = res_zeroes_q;
  assign res_runs_o        = res_runs_q;
  assign res_longest_run_o = res_longest_q;
  assign res_balanced_o    = res_balanced_q;
  assign res_valid_o       = res_valid_q;
  assign res_overrun_o     = res_overrun_q;

endmodule

// File: tb/tb_lfsr_bit_stats.sv
// Directed bench for lfsr_bit_stats: hand-computed period results, handshake, overrun,
// saturation, balance tolerance and a full 16-bit XNOR LFSR period.
module tb_lfsr_bit_stats;

  logic        clk, reset;
  logic        bit_in, bit_valid, period_tick, res_ready;
  logic [15:0] res_ones, res_zeroes, res_runs;
  logic [7:0]  res_longest_run;
  logic        res_balanced, res_valid, res_overrun;
  logic [15:0] t90_ones, t90_zeroes, t90_runs;
  logic [7:0]  t90_longest_run;
  logic        t90_balanced, t90_valid, t90_overrun;

  int n_checks = 0;
  int n_pass   = 0;

  lfsr_bit_stats u_dut (
    .clk               (clk),
    .reset             (reset),
    .bit_in_i          (bit_in),
    .bit_valid_i       (bit_valid),
    .period_tick_i     (period_tick),
    .res_ones_o        (res_ones),
    .res_zeroes_o      (res_zeroes),
    .res_runs_o        (res_runs),
    .res_longest_run_o (res_longest_run),
    .res_balanced_o    (res_balanced),
    .res_valid_o       (res_valid),
    .res_ready_i       (res_ready),
    .res_overrun_o     (res_overrun)
  );

  lfsr_bit_stats #(.BAL_TOL(90)) u_dut90 (
    .clk               (clk),
    .reset             (reset),
    .bit_in_i          (bit_in),
    .bit_valid_i       (bit_valid),
    .period_tick_i     (period_tick),
    .res_ones_o        (t90_ones),
    .res_zeroes_o      (t90_zeroes),
    .res_runs_o        (t90_runs),
    .res_longest_run_o (t90_longest_run),
    .res_balanced_o    (t90_balanced),
    .res_valid_o       (t90_valid),
    .res_ready_i       (res_ready),
    .res_overrun_o     (t90_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic drive(input logic b, input logic v, input logic t);
    bit_in      = b;
    bit_valid   = v;
    period_tick = t;
    @(negedge clk);
  endtask

  task automatic check_res(input string tag, input int ones, input int zeroes, input int runs,
                           input int longest, input int bal);
    check({tag, "_ones"},    32'(res_ones),        ones);
    check({tag, "_zeroes"},  32'(res_zeroes),      zeroes);
    check({tag, "_runs"},    32'(res_runs),        runs);
    check({tag, "_longest"}, 32'(res_longest_run), longest);
    check({tag, "_bal"},     32'(res_balanced),    bal);
  endtask

  logic [15:0] lfsr;

  initial begin
    reset = 1'b1; res_ready = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b0; period_tick = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_valid",   32'(res_valid),   0);
    check("rst_overrun", 32'(res_overrun), 0);
    check_res("rst", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Stream 1,1,0,0,0,1 then tick.
    drive(1'b0, 1'b1, 1'b0);  // ignored in idle
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check("t2_valid_pre", 32'(res_valid), 0);
    drive(1'b0, 1'b1, 1'b1);
    check("t2_valid_post", 32'(res_valid), 1);
    check_res("t2", 3, 3, 3, 3, 1);
    res_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("t2_valid_drop", 32'(res_valid), 0);
    res_ready = 1'b0;

    // Period started with a 0 tick bit: 9 more zeroes then 100 ones.
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check_res("t6", 100, 10, 2, 100, 0);
    check("t6_bal90",  32'(t90_balanced), 1);
    check("t6_overrun", 32'(res_overrun), 0);

    // 300 ones (tick bit counted), with invalid gaps and an unqualified tick.
    for (int i = 0; i < 299; i++) begin
      if (i % 50 == 25) begin
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
      end
      drive(1'b1, 1'b1, 1'b0);
    end
    check("t4_stable_ones", 32'(res_ones), 100);
    drive(1'b0, 1'b1, 1'b1);
    check_res("t5", 300, 0, 1, 255, 0);
    check("t4_overrun_set", 32'(res_overrun), 1);
    check("t4_valid_held",  32'(res_valid),   1);

    // Reset mid-period with an unread result.
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("t1_valid",   32'(res_valid),   0);
    check("t1_overrun", 32'(res_overrun), 0);
    check_res("t1", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check_res("t1_restart", 2, 1, 3, 1, 1);
    check("t1_restart_valid", 32'(res_valid), 1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    res_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    check_res("t4_swap", 1, 2, 2, 2, 1);
    check("t4_swap_valid",   32'(res_valid),   1);
    check("t4_swap_overrun", 32'(res_overrun), 0);

    // Full XNOR LFSR period, taps 16,15,13,4, seeded at 0; tick whenever the state is the seed.
    lfsr = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      drive(lfsr[15], 1'b1, lfsr == 16'h0000);
      lfsr = {lfsr[14:0], ~(lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3])};
    end
    check("t3_valid", 32'(res_valid), 1);
    check_res("t3", 32767, 32768, 32768, 16, 1);
    check("t3_overrun", 32'(res_overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
